ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port `RAM` block (synchronous write, combinational read). It sits between two independent masters and one `RAM` instance. It serialises their read/write requests with round-robin fairness, drives the RAM's `we`/`addr`/`D` inputs, and returns registered read data and a one-cycle acknowledge to the winning master.

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 99 +++++++++
 tb/tb_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle of the two master request ports and the single-port RAM connection
// used by ram_arbiter.
interface ram_arbiter_if #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
);
    logic                   req0;
    logic                   req1;
    logic                   we0;
    logic                   we1;
    logic [AddressSize-1:0] addr0;
    logic [AddressSize-1:0] addr1;
    logic [Width-1:0]       D0;
    logic [Width-1:0]       D1;
    logic                   ack0;
    logic                   ack1;
    logic [Width-1:0]       Q0;
    logic [Width-1:0]       Q1;
    logic                   busy;
    logic                   ram_we;
    logic [AddressSize-1:0] ram_addr;
    logic [Width-1:0]       ram_D;
    logic [Width-1:0]       ram_Q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, D0, D1, ram_Q,
        output ack0, ack1, Q0, Q1, busy, ram_we, ram_addr, ram_D
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, D0, D1, ram_Q,
        input  ack0, ack1, Q0, Q1, busy, ram_we, ram_addr, ram_D
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two masters onto one single-port RAM;
// one-cycle ACCESS per transaction, registered read data and ack pulse.
module ram_arbiter #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic                   gnt_q, gnt_d;
    logic                   we_l_q, we_l_d;
    logic [AddressSize-1:0] addr_l_q, addr_l_d;
    logic [Width-1:0]       D_l_q, D_l_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [Width-1:0]       Q0_q, Q0_d;
    logic [Width-1:0]       Q1_q, Q1_d;
    logic                   el0, el1, win;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        we_l_d   = we_l_q;
        addr_l_d = addr_l_q;
        D_l_d    = D_l_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        Q0_d     = Q0_q;
        Q1_d     = Q1_q;
        // a master in its ack cycle is not yet a new request
        el0      = bus.req0 & ~ack0_q;
        el1      = bus.req1 & ~ack1_q;
        win      = (el0 & el1) ? prio_q : el1;
        unique case (state_q)
            IDLE: begin
                if (el0 | el1) begin
                    state_d  = ACCESS;
                    gnt_d    = win;
                    prio_d   = ~win;
                    we_l_d   = win ? bus.we1   : bus.we0;
                    addr_l_d = win ? bus.addr1 : bus.addr0;
                    D_l_d    = win ? bus.D1    : bus.D0;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    if (!we_l_q) Q1_d = bus.ram_Q;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_l_q) Q0_d = bus.ram_Q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            we_l_q   <= 1'b0;
            addr_l_q <= '0;
            D_l_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            Q0_q     <= '0;
            Q1_q     <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            we_l_q   <= we_l_d;
            addr_l_q <= addr_l_d;
            D_l_q    <= D_l_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            Q0_q     <= Q0_d;
            Q1_q     <= Q1_d;
        end
    end

    // reset must block an in-flight write immediately
    assign bus.ram_we   = (state_q == ACCESS) & we_l_q & ~rst;
    assign bus.ram_addr = addr_l_q;
    assign bus.ram_D    = D_l_q;
    assign bus.busy     = (state_q == ACCESS);
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.Q0       = Q0_q;
    assign bus.Q1       = Q1_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised self-checking bench for ram_arbiter with a behavioural RAM and
// a transaction-level model of memory contents, read data and fairness.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.Width(8), .AddressSize(4)) bus ();
    ram_arbiter #(.Width(8), .AddressSize(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [16];
    always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_D;
    assign bus.ram_Q = ram[bus.ram_addr];

    logic [7:0] exp_mem [16];
    logic [7:0] exp_q [2];
    int prio_m;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input bit r, input bit w,
                         input logic [3:0] a, input logic [7:0] d);
        if (m == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.D0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.D1 = d;
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? bus.ack0 : bus.ack1;
    endfunction

    // one isolated transaction from an idle arbiter
    task automatic do_txn(input int m, input bit w, input logic [3:0] a,
                          input logic [7:0] d);
        int cyc = 0;
        int wecnt = 0;
        bit got = 0;
        drive(m, 1, w, a, d);
        while (!got && cyc < 8) begin
            tick();
            cyc++;
            if (bus.ram_we) begin
                wecnt++;
                check("wr_addr", bus.ram_addr, a);
                check("wr_data", bus.ram_D, d);
            end
            check("other_ack", ack_of(1 - m), 0);
            if (ack_of(m)) got = 1;
        end
        drive(m, 0, w, a, d);
        check("ack_seen", got, 1);
        check("latency", cyc, 2);
        check("we_cycles", wecnt, w);
        if (w) exp_mem[a] = d;
        else exp_q[m] = exp_mem[a];
        check("Q0", bus.Q0, exp_q[0]);
        check("Q1", bus.Q1, exp_q[1]);
        if (got) prio_m = 1 - m;
        tick();
        check("no_extra", bus.busy, 0);
    endtask

    task automatic contention(input int nacks);
        logic [3:0] a0 = 0;
        logic [7:0] d0 = 8'($urandom);
        logic [3:0] a1 = 4'($urandom);
        int last_t [2] = '{-1, -1};
        int cyc = 0;
        int seen = 0;
        int expw = prio_m;
        int m;
        drive(0, 1, 1, a0, d0);
        drive(1, 1, 0, a1, 8'h00);
        while (seen < nacks && cyc < nacks * 4 + 8) begin
            tick();
            cyc++;
            check("ack_overlap", bus.ack0 & bus.ack1, 0);
            if (bus.ack0 | bus.ack1) begin
                m = bus.ack1 ? 1 : 0;
                check("grant_order", m, expw);
                expw = 1 - m;
                prio_m = 1 - m;
                if (last_t[m] >= 0) check("ack_period", cyc - last_t[m], 4);
                last_t[m] = cyc;
                seen++;
                if (m == 0) begin
                    exp_mem[a0] = d0;
                    a0 = a0 + 4'd1;
                    d0 = 8'($urandom);
                    drive(0, 1, 1, a0, d0);
                end else begin
                    exp_q[1] = exp_mem[a1];
                    check("cont_Q1", bus.Q1, exp_q[1]);
                    a1 = 4'($urandom);
                    drive(1, 1, 0, a1, 8'h00);
                end
                check("cont_Q0", bus.Q0, exp_q[0]);
                if (seen == nacks) begin
                    drive(0, 0, 0, a0, d0);
                    drive(1, 0, 0, a1, 8'h00);
                end
            end
        end
        check("cont_done", seen, nacks);
        drive(0, 0, 0, a0, d0);
        drive(1, 0, 0, a1, 8'h00);
        tick();
        check("cont_idle", bus.busy, 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] sweep [16];
        int cyc, nack, t1, t2, wecnt;
        bit first0, first1;

        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            exp_mem[i] = v;
        end
        exp_q[0] = 8'h00;
        exp_q[1] = 8'h00;
        prio_m = 0;

        rst = 1'b1;
        drive(0, 1, 0, 4'd0, 8'h00);
        drive(1, 1, 0, 4'd1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ack0", bus.ack0, 0);
            check("rst_ack1", bus.ack1, 0);
            check("rst_Q0", bus.Q0, 0);
            check("rst_Q1", bus.Q1, 0);
            check("rst_we", bus.ram_we, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_addr", bus.ram_addr, 0);
            check("rst_D", bus.ram_D, 0);
        end
        rst = 1'b0;
        cyc = 0;
        first0 = 0;
        first1 = 0;
        while (!(first0 | first1) && cyc < 8) begin
            tick();
            cyc++;
            first0 = bus.ack0;
            first1 = bus.ack1;
        end
        drive(0, 0, 0, 4'd0, 8'h00);
        drive(1, 0, 0, 4'd1, 8'h00);
        check("first_gnt0", first0, 1);
        check("first_gnt1", first1, 0);
        check("first_lat", cyc, 2);
        exp_q[0] = exp_mem[0];
        check("first_Q0", bus.Q0, exp_q[0]);
        prio_m = 1;
        tick();

        do_txn(0, 1, 4'd3, 8'hA5);
        do_txn(0, 0, 4'd3, 8'h00);

        contention(12);

        for (int i = 0; i < 16; i++) begin
            sweep[i] = 8'($urandom);
            do_txn(1, 1, 4'(i), sweep[i]);
        end
        for (int i = 0; i < 16; i++) begin
            do_txn(1, 0, 4'(i), 8'h00);
            check("sweep_Q1", bus.Q1, sweep[i]);
        end

        for (int i = 0; i < 20; i++)
            do_txn(int'($urandom_range(1)), 1'($urandom), 4'($urandom),
                   8'($urandom));

        contention(9);

        drive(0, 1, 1, 4'd7, 8'h3C);
        tick();
        check("rm_busy", bus.busy, 1);
        check("rm_we_pre", bus.ram_we, 1);
        rst = 1'b1;
        #1;
        check("rm_we", bus.ram_we, 0);
        drive(0, 0, 0, 4'd7, 8'h00);
        tick();
        check("rm_ack0", bus.ack0, 0);
        check("rm_busy_post", bus.busy, 0);
        check("rm_Q0", bus.Q0, 0);
        check("rm_Q1", bus.Q1, 0);
        rst = 1'b0;
        exp_q[0] = 8'h00;
        exp_q[1] = 8'h00;
        prio_m = 0;
        do_txn(0, 0, 4'd7, 8'h00);

        v = 8'($urandom);
        drive(0, 1, 1, 4'd9, v);
        cyc = 0;
        nack = 0;
        t1 = 0;
        t2 = 0;
        wecnt = 0;
        while (nack < 2 && cyc < 12) begin
            tick();
            cyc++;
            if (bus.ram_we) wecnt++;
            if (bus.ack0) begin
                nack++;
                if (nack == 1) begin
                    t1 = cyc;
                    check("keep_ackcyc_busy", bus.busy, 0);
                end else begin
                    t2 = cyc;
                    drive(0, 0, 1, 4'd9, v);
                end
            end
        end
        drive(0, 0, 1, 4'd9, v);
        exp_mem[9] = v;
        prio_m = 1;
        check("keep_acks", nack, 2);
        check("keep_lat1", t1, 2);
        check("keep_gap", t2 - t1, 3);
        check("keep_writes", wecnt, 2);
        tick();
        check("keep_idle", bus.busy, 0);
        do_txn(1, 0, 4'd9, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
